// File: rtl/booth_pkg.sv
// Shared types and helpers for the booth multiplier scheduler.
package booth_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  // Cycles after the load edge until the radix-4 sequential multiplier's P is final.
  function automatic int booth_mult_latency(input int b_width);
    return 3 * ((b_width + 2) / 2) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// rr_ptr, wrapping. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                any_grant
);

  // Scan candidates starting at the pointer; the first valid one wins.
  always_comb begin
    int cand;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!any_grant && req[cand[ID_WIDTH-1:0]]) begin
        any_grant                   = 1'b1;
        grant_idx                   = cand[ID_WIDTH-1:0];
        grant[cand[ID_WIDTH-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mult_sched.sv
// Shares one sequential radix-4 booth multiplier among NUM_REQ requesters.
// Round-robin grant, fixed-latency wait for the product, single valid/ready
// response channel carrying the product and requester index.
// Optional feature macro: BOOTH_SCHED_ZERO_BYPASS_EN -- when defined, a grant
// with a zero operand skips the multiplier and responds with 0 immediately.
module booth_mult_sched
  import booth_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int A_WIDTH      = 6,
  parameter int B_WIDTH      = 6,
  parameter int P_WIDTH      = A_WIDTH + B_WIDTH + 1,
  parameter int MULT_LATENCY = booth_mult_latency(B_WIDTH),
  parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [P_WIDTH-1:0]           rsp_p,
  output logic                         mult_load,
  output logic [A_WIDTH-1:0]           mult_a,
  output logic [B_WIDTH-1:0]           mult_b,
  input  logic [P_WIDTH-1:0]           mult_p,
  output logic                         busy
);

  localparam int CNT_W = $clog2(MULT_LATENCY + 1);

  sched_state_t          state_q,    state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [ID_WIDTH-1:0]   gnt_id_q,   gnt_id_d;
  logic [A_WIDTH-1:0]    op_a_q,     op_a_d;
  logic [B_WIDTH-1:0]    op_b_q,     op_b_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [P_WIDTH-1:0]    rsp_p_q,    rsp_p_d;
  logic [ID_WIDTH-1:0]   rsp_id_q,   rsp_id_d;

  logic [A_WIDTH-1:0]    req_a_arr [NUM_REQ];
  logic [B_WIDTH-1:0]    req_b_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  any_grant;
  logic [A_WIDTH-1:0]    gnt_a;
  logic [B_WIDTH-1:0]    gnt_b;

  // Split the packed operand buses into per-requester slices.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_a_arr[gi] = req_a[gi*A_WIDTH +: A_WIDTH];
    assign req_b_arr[gi] = req_b[gi*B_WIDTH +: B_WIDTH];
  end

  assign gnt_a = req_a_arr[grant_idx];
  assign gnt_b = req_b_arr[grant_idx];

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Operands go straight from the registers so they stay put until the next grant.
  assign mult_a = op_a_q;
  assign mult_b = op_b_q;
  assign rsp_p  = rsp_p_q;
  assign rsp_id = rsp_id_q;

  // Next-state and output decode for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    wait_cnt_d = wait_cnt_q;
    rsp_p_d    = rsp_p_q;
    rsp_id_d   = rsp_id_q;
    req_ready  = '0;
    mult_load  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (any_grant) begin
          op_a_d   = gnt_a;
          op_b_d   = gnt_b;
          gnt_id_d = grant_idx;
          rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = ISSUE;
`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
          // A zero operand makes the product trivially zero; skip the multiplier.
          if ((gnt_a == '0) || (gnt_b == '0)) begin
            rsp_p_d  = '0;
            rsp_id_d = grant_idx;
            state_d  = RESP;
          end
`endif
        end
      end
      ISSUE: begin
        mult_load  = 1'b1;
        wait_cnt_d = CNT_W'(MULT_LATENCY);
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        if (wait_cnt_q == CNT_W'(1)) begin
          rsp_p_d  = mult_p;
          rsp_id_d = gnt_id_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      wait_cnt_q <= '0;
      rsp_p_q    <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      wait_cnt_q <= wait_cnt_d;
      rsp_p_q    <= rsp_p_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_booth_mult_sched.sv
// Self-checking bench for booth_mult_sched with a behavioural fixed-latency
// multiplier model and a response scoreboard.
module tb_booth_mult_sched;

  localparam int NR  = 4;
  localparam int AW  = 6;
  localparam int BW  = 6;
  localparam int PW  = 13;
  localparam int IW  = 2;
  localparam int LAT = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_a;
  logic [NR*BW-1:0]  req_b;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [PW-1:0]     rsp_p;
  logic              mult_load;
  logic [AW-1:0]     mult_a;
  logic [BW-1:0]     mult_b;
  logic [PW-1:0]     mult_p;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_mult_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .mult_load (mult_load),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .busy      (busy)
  );

  // Multiplier model: P shows a wrong value until LAT edges after the load edge.
  int               mcnt;
  logic [PW-1:0]    mprod;
  always @(posedge clk) begin
    if (rst) begin
      mcnt   <= 0;
      mult_p <= '0;
      mprod  <= '0;
    end else if (mult_load) begin
      mprod  <= PW'($signed(mult_a) * $signed(mult_b));
      mult_p <= ~PW'($signed(mult_a) * $signed(mult_b));
      mcnt   <= 1;
    end else if (mcnt > 0 && mcnt < LAT) begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 == LAT) mult_p <= mprod;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard and monitor.
  typedef struct {
    int            id;
    logic [PW-1:0] p;
    int            acc;
    int            lat;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
  } exp_t;

  exp_t          sb[$];
  int            acc_id_log[$];
  int            acc_cyc_log[$];
  int            hs_count = 0;
  logic          prev_rv, prev_hs;
  logic [PW-1:0] prev_p, last_p;
  logic [IW-1:0] prev_id, last_id;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_rv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (busy) chk("req_ready_while_busy", req_ready, 0);
      else      chk("req_ready_onehot", ($countones(req_ready) <= 1), 1);
      if (prev_hs && (|req_valid)) chk("grant_after_rsp", |req_ready, 1);

      if (sb.size() > 0 && cyc == sb[0].acc + 1) begin
        chk("mult_load_issue", mult_load, (sb[0].lat != 1));
        if (sb[0].lat != 1) begin
          chk("mult_a_issue", mult_a, sb[0].a);
          chk("mult_b_issue", mult_b, sb[0].b);
        end
      end else if (mult_load) begin
        chk("stray_mult_load", mult_load, 0);
      end

      if (rsp_valid && !prev_rv) begin
        if (sb.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
        else                chk("rsp_latency", cyc - sb[0].acc, sb[0].lat);
      end
      if (rsp_valid && prev_rv && !prev_hs) begin
        chk("rsp_p_stable", rsp_p, prev_p);
        chk("rsp_id_stable", rsp_id, prev_id);
      end
      if (rsp_valid && rsp_ready) begin
        hs_count++;
        last_p  = rsp_p;
        last_id = rsp_id;
        if (sb.size() > 0) begin
          chk("rsp_id", rsp_id, sb[0].id);
          chk("rsp_p", rsp_p, sb[0].p);
          $display("rsp id=%0d p=%0d at cycle %0d", rsp_id, $signed(rsp_p), cyc);
          void'(sb.pop_front());
        end
      end

      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          logic signed [AW-1:0] sa;
          logic signed [BW-1:0] sbv;
          sa    = req_a[i*AW +: AW];
          sbv   = req_b[i*BW +: BW];
          e.id  = i;
          e.a   = sa;
          e.b   = sbv;
          e.p   = PW'(int'(sa) * int'(sbv));
          e.acc = cyc;
`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
          e.lat = (sa == 0 || sbv == 0) ? 1 : LAT + 2;
`else
          e.lat = LAT + 2;
`endif
          sb.push_back(e);
          acc_id_log.push_back(i);
          acc_cyc_log.push_back(cyc);
          $display("accept id=%0d a=%0d b=%0d at cycle %0d", i, sa, sbv, cyc);
        end
      end

      prev_rv = rsp_valid;
      prev_hs = rsp_valid && rsp_ready;
      prev_p  = rsp_p;
      prev_id = rsp_id;
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    logic [31:0] av, bv;
    av = a;
    bv = b;
    req_a[i*AW +: AW] = av[AW-1:0];
    req_b[i*BW +: BW] = bv[BW-1:0];
  endtask

  task automatic req_accept(input int i, input int a, input int b);
    logic got;
    got = 1'b0;
    set_ops(i, a, b);
    req_valid[i] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", got, 1);
    next_cyc();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp_valid();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("rsp_valid_timeout", got, 1);
    next_cyc();
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("rsp_handshake_timeout", got, 1);
    next_cyc();
  endtask

  task automatic check_reset(input string tag);
    $display("reset check %s at cycle %0d", tag, cyc);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"},    rsp_id,    0);
    chk({tag, "_rsp_p"},     rsp_p,     0);
    chk({tag, "_mult_load"}, mult_load, 0);
    chk({tag, "_mult_a"},    mult_a,    0);
    chk({tag, "_mult_b"},    mult_b,    0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_before;
    logic [PW-1:0] exp_p;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) next_cyc();
    @(negedge clk);
    check_reset("init");
    next_cyc();
    rst = 1'b0;

    // Fairness: all requesters valid from reset, served 0,1,2,3,0 sixteen cycles apart.
    acc_id_log.delete();
    acc_cyc_log.delete();
    for (int i = 0; i < NR; i++) set_ops(i, i + 1, -(i + 2));
    req_valid = '1;
    for (int n = 0; n < 200; n++) begin
      next_cyc();
      if (acc_id_log.size() >= 5) break;
    end
    req_valid = '0;
    wait_done();
    chk("fair_count", acc_id_log.size(), 5);
    for (int k = 0; k < 5 && k < acc_id_log.size(); k++) begin
      chk("fair_order", acc_id_log[k], k % NR);
      if (k > 0) chk("fair_spacing", acc_cyc_log[k] - acc_cyc_log[k-1], LAT + 3);
    end

    // Single request: 5 * -3.
    req_accept(0, 5, -3);
    wait_done();
    exp_p = PW'(-15);
    chk("single_p", last_p, exp_p);
    chk("single_id", last_id, 0);

    // Zero operand passes through (full latency unless bypass is built in).
    req_accept(3, 0, 13);
    wait_done();
    chk("zero_p", last_p, 0);

    // Backpressure with extreme operands; another requester waits meanwhile.
    rsp_ready = 1'b0;
    req_accept(1, 31, -32);
    wait_rsp_valid();
    set_ops(2, -32, -32);
    req_valid[2] = 1'b1;
    repeat (10) next_cyc();
    @(negedge clk);
    chk("bp_held_valid", rsp_valid, 1);
    chk("bp_no_grant", req_ready, 0);
    next_cyc();
    rsp_ready = 1'b1;
    req_accept(2, -32, -32);
    exp_p = PW'(-992);
    chk("bp_p", last_p, exp_p);
    chk("bp_id", last_id, 1);
    wait_done();
    chk("extreme_p", last_p, 1024);
    chk("extreme_id", last_id, 2);

    // Reset in the middle of WAIT: the operation is dropped.
    hs_before = hs_count;
    req_accept(0, 3, 3);
    repeat (5) next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    check_reset("midwait");
    repeat (20) next_cyc();
    chk("abort_no_rsp", hs_count, hs_before);
    req_accept(2, 7, 7);
    wait_done();
    chk("post_reset_p", last_p, 49);
    chk("post_reset_id", last_id, 2);

    repeat (3) next_cyc();
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
